// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side target of the core's data port (req/gnt/rvalid protocol).
// Holds MEM_WORDS words of storage and accepts one request at a time. Writes
// are committed with byte enables at the accept edge. Read data is sampled at
// the accept edge and returned LATENCY cycles later. A misaligned or
// out-of-range access gets an error response and leaves storage untouched.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req_i     in   access request; addr/we/be/wdata held stable while high
//   gnt_o     out  request accepted this cycle (combinational)
//   addr_i    in   byte address
//   we_i      in   1 = write, 0 = read
//   be_i      in   byte enables, bit n = byte lane n
//   wdata_i   in   store data, lanes already positioned
//   rvalid_o  out  response valid, one cycle per accepted request
//   rdata_o   out  read word; zero unless an error-free read response
//   err_o     out  response is an error; qualified by rvalid_o
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter int unsigned             LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [DATA_WIDTH-1:0]   hold_data_q;
    logic                    hold_err_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   off;
    logic                    acc_err;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   rd_word;

    // No grant while a response is still being counted down, nor in reset.
    assign gnt_o  = rst_n & req_i & (state_q != S_WAIT);
    assign accept = req_i & gnt_o;

    // BASE_ADDR is word aligned, so the low offset bits equal addr_i[1:0].
    assign off     = addr_i - BASE_ADDR;
    assign acc_err = (|off[1:0])
                   | (addr_i < BASE_ADDR)
                   | ({2'b00, off[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_WORDS));
    assign idx     = off[IDX_W+1:2];

    // Response word captured at accept: zero for writes and errors.
    assign rd_word = (we_i || acc_err) ? '0 : mem_q[idx];

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && we_i && !acc_err) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            // Output registers default to the quiet (all-zero) response.
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        hold_data_q <= rd_word;
                        hold_err_q  <= acc_err;
                        if (LATENCY == 1) begin
                            state_q  <= S_RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rd_word;
                            err_q    <= acc_err;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(LATENCY - 2);
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= hold_data_q;
                        err_q    <= hold_err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    // Instance 0: LATENCY 1, base 0; instance 1: LATENCY 3, base 0x1000.
    localparam int MW0 = 64;
    localparam int MW1 = 16;

    logic        clk;
    logic        rst  [2];
    logic        req  [2];
    logic        gnt  [2];
    logic [31:0] addr [2];
    logic        we   [2];
    logic [3:0]  be   [2];
    logic [31:0] wdata[2];
    logic        rvalid[2];
    logic [31:0] rdata[2];
    logic        err  [2];

    logic [31:0] mdl [2][64];

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    data_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(MW0),
        .BASE_ADDR(32'h0), .LATENCY(1)
    ) u_l1 (
        .clk(clk), .rst_n(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]),
        .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );

    data_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(MW1),
        .BASE_ADDR(32'h1000), .LATENCY(3)
    ) u_l3 (
        .clk(clk), .rst_n(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]),
        .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint base_of(input int d);
        return (d == 0) ? 64'h0 : 64'h1000;
    endfunction

    function automatic longint words_of(input int d);
        return (d == 0) ? MW0 : MW1;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic model_err(input int d, input logic [31:0] a);
        longint av = longint'(a);
        if (av % 4 != 0) return 1'b1;
        if (av < base_of(d)) return 1'b1;
        return ((av - base_of(d)) / 4) >= words_of(d);
    endfunction

    function automatic int model_idx(input int d, input logic [31:0] a);
        return int'((longint'(a) - base_of(d)) / 4);
    endfunction

    // One isolated transaction with req held until the response cycle.
    task automatic txn(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd, input string tag);
        logic        e;
        logic [31:0] exp_d;
        int          lat = lat_of(d);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        #1;
        chk({tag, ".gnt"}, 32'(gnt[d]), 32'd1);
        e     = model_err(d, a);
        exp_d = '0;
        if (!w && !e) exp_d = mdl[d][model_idx(d, a)];
        if (w && !e) begin
            for (int l = 0; l < 4; l++)
                if (b[l]) mdl[d][model_idx(d, a)][8*l +: 8] = wd[8*l +: 8];
        end
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (k < lat - 1) begin
                chk({tag, ".rvalid_wait"}, 32'(rvalid[d]), 32'd0);
                chk({tag, ".gnt_wait"}, 32'(gnt[d]), 32'd0);
                chk({tag, ".rdata_wait"}, rdata[d], 32'd0);
                chk({tag, ".err_wait"}, 32'(err[d]), 32'd0);
            end else begin
                chk({tag, ".rvalid"}, 32'(rvalid[d]), 32'd1);
                chk({tag, ".rdata"}, rdata[d], exp_d);
                chk({tag, ".err"}, 32'(err[d]), 32'(e));
            end
        end
        req[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          d;
        int          r;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; req[i] = 1'b1; addr[i] = '0; we[i] = 1'b0;
            be[i] = '0; wdata[i] = '0;
        end

        // Reset state, with req asserted to show gnt is held low.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset.gnt", 32'(gnt[i]), 32'd0);
            chk("reset.rvalid", 32'(rvalid[i]), 32'd0);
            chk("reset.rdata", rdata[i], 32'd0);
            chk("reset.err", 32'(err[i]), 32'd0);
        end
        rst[0] = 1'b1; rst[1] = 1'b1; req[0] = 1'b0; req[1] = 1'b0;

        // Fill both memories so later reads have defined contents.
        for (int i = 0; i < MW0; i++) txn(0, 1'b1, 32'(4*i), 4'hF, $urandom, "init0");
        for (int i = 0; i < MW1; i++) txn(1, 1'b1, 32'h1000 + 32'(4*i), 4'hF, $urandom, "init1");

        // Basic write/read at LATENCY 1.
        txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "t1.wr");
        txn(0, 1'b0, 32'h10, 4'h0, 32'h0, "t1.rd");

        // Byte-lane merge.
        txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344, "t2.wr1");
        txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, "t2.wr2");
        txn(0, 1'b0, 32'h20, 4'hF, 32'h0, "t2.rd");
        txn(0, 1'b1, 32'h24, 4'h0, 32'hFFFFFFFF, "t2.be0");
        txn(0, 1'b0, 32'h24, 4'h0, 32'h0, "t2.rd0");

        // LATENCY 3 with held request stalling.
        txn(1, 1'b1, 32'h1004, 4'b1100, 32'h5A5A0000, "t3.wr");
        txn(1, 1'b0, 32'h1004, 4'hF, 32'h0, "t3.rd");

        // Back-to-back reads at LATENCY 1, one per cycle.
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("t4.rvalid", 32'(rvalid[0]), 32'd1);
                chk("t4.rdata", rdata[0], mdl[0][i-1]);
                chk("t4.err", 32'(err[0]), 32'd0);
            end
            if (i < 4) begin
                req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'(4*i);
                #1;
                chk("t4.gnt", 32'(gnt[0]), 32'd1);
            end else begin
                req[0] = 1'b0;
            end
        end
        @(negedge clk);
        chk("t4.idle_rvalid", 32'(rvalid[0]), 32'd0);

        // Error responses and untouched storage.
        txn(0, 1'b0, 32'h13, 4'hF, 32'h0, "t5.misalign");
        txn(0, 1'b0, 32'(4*MW0), 4'hF, 32'h0, "t5.oor_rd");
        txn(0, 1'b1, 32'(4*MW0), 4'hF, 32'hCAFEF00D, "t5.oor_wr");
        txn(0, 1'b1, 32'h22, 4'hF, 32'hCAFEF00D, "t5.mis_wr");
        txn(0, 1'b1, 32'hFFFFFFFC, 4'hF, 32'hCAFEF00D, "t5.top_wr");
        txn(1, 1'b0, 32'h0FFC, 4'hF, 32'h0, "t5.below");
        txn(1, 1'b1, 32'h1000 + 32'(4*MW1), 4'hF, 32'h12345678, "t5.oor_wr1");
        for (int i = 0; i < MW0; i++) txn(0, 1'b0, 32'(4*i), 4'hF, 32'h0, "t5.scan0");
        for (int i = 0; i < MW1; i++) txn(1, 1'b0, 32'h1000 + 32'(4*i), 4'h0, 32'h0, "t5.scan1");

        // Reset while a LATENCY 3 read is counting down.
        txn(1, 1'b1, 32'h1008, 4'hF, 32'h87654321, "t6.wr");
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h1008; be[1] = 4'hF;
        #1;
        chk("t6.gnt", 32'(gnt[1]), 32'd1);
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        chk("t6.rst_rvalid", 32'(rvalid[1]), 32'd0);
        chk("t6.rst_gnt", 32'(gnt[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b1; req[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t6.no_rvalid", 32'(rvalid[1]), 32'd0);
        end
        txn(1, 1'b0, 32'h1008, 4'hF, 32'h0, "t6.rd");

        // Randomised traffic against the model.
        for (int n = 0; n < 150; n++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0)
                a = 32'(base_of(d)) + 32'(4*$urandom_range(0, words_of(d) - 1)) + 32'($urandom_range(1, 3));
            else if (r == 1)
                a = 32'(base_of(d)) + 32'(4*words_of(d)) + 32'(4*$urandom_range(0, 7));
            else if (r == 2 && d == 1)
                a = 32'(base_of(d)) - 32'(4*$urandom_range(1, 8));
            else
                a = 32'(base_of(d)) + 32'(4*$urandom_range(0, words_of(d) - 1));
            txn(d, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
